// File: rtl/sbox_share_sequencer_if.sv
// ---------------------------------------------------------------------------
// sbox_share_sequencer_if
// Handshake bundle between a producer/consumer and the S-box share sequencer.
//   in_valid / in_ready       : accept one masked nibble (NSHARE=3 shares)
//   in_s0, in_s1, in_s2       : input shares, NIB bits each
//   out_valid / out_ready     : hand back one captured masked result
//   out_s0, out_s1, out_s2    : output shares, NIB bits each
// Modports:
//   master : the producer/consumer side (drives in_*, out_ready)
//   slave  : the sequencer side (drives in_ready, out_valid, out_s*)
// ---------------------------------------------------------------------------
interface sbox_share_sequencer_if #(
  parameter int NIB = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [NIB-1:0] in_s0;
  logic [NIB-1:0] in_s1;
  logic [NIB-1:0] in_s2;
  logic           out_valid;
  logic           out_ready;
  logic [NIB-1:0] out_s0;
  logic [NIB-1:0] out_s1;
  logic [NIB-1:0] out_s2;

  modport master (
    output in_valid, in_s0, in_s1, in_s2, out_ready,
    input  in_ready, out_valid, out_s0, out_s1, out_s2
  );

  modport slave (
    input  in_valid, in_s0, in_s1, in_s2, out_ready,
    output in_ready, out_valid, out_s0, out_s1, out_s2
  );
endinterface

// File: rtl/sbox_share_sequencer.sv
// ---------------------------------------------------------------------------
// sbox_share_sequencer
// Control stage wrapped around a 2nd-order masked 4-bit Skinny S-box
// (3 shares, HPC1, clock-gated output register). Accepts one 3-share nibble,
// holds the shares on the S-box inputs, restarts the S-box gating controller,
// waits for its Synch, captures the 3 output shares and hands them on.
// Shares are never combined: each one travels in its own register.
//
// Ports:
//   clk          system clock (same clock as the S-box)
//   rst          synchronous active-high reset
//   bus          handshake bundle (slave modport): in_* / out_*
//   sbox_si_s*   shares held on the S-box SI inputs
//   sbox_rst     S-box gating-controller restart (high in START and in rst)
//   sbox_synch   S-box Synch
//   sbox_so_s*   S-box SO outputs
//   busy         high in every state except IDLE
//   err          sticky: Synch timeout or Synch earlier than LATENCY
//
// Optional build macro SBOX_SEQ_CLEAR_EN: when defined, the S-box input
// shares are zeroed on the OUT->IDLE transition so stale shares do not sit
// on the S-box between operations.
// ---------------------------------------------------------------------------
module sbox_share_sequencer #(
  parameter int NSHARE  = 3,
  parameter int NIB     = 4,
  parameter int LATENCY = 11,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  sbox_share_sequencer_if.slave bus,
  output logic [NIB-1:0] sbox_si_s0,
  output logic [NIB-1:0] sbox_si_s1,
  output logic [NIB-1:0] sbox_si_s2,
  output logic           sbox_rst,
  input  logic           sbox_synch,
  input  logic [NIB-1:0] sbox_so_s0,
  input  logic [NIB-1:0] sbox_so_s1,
  input  logic [NIB-1:0] sbox_so_s2,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_cap;        // Synch sampled; capture on the next edge
  logic           r_err;
  logic           r_out_valid;
  logic [NIB-1:0] r_si  [NSHARE];
  logic [NIB-1:0] r_out [NSHARE];

  logic [NIB-1:0] w_in [NSHARE];
  logic [NIB-1:0] w_so [NSHARE];

  assign w_in[0] = bus.in_s0;
  assign w_in[1] = bus.in_s1;
  assign w_in[2] = bus.in_s2;
  assign w_so[0] = sbox_so_s0;
  assign w_so[1] = sbox_so_s1;
  assign w_so[2] = sbox_so_s2;

  // in_ready/sbox_rst follow rst combinationally so they are correct even
  // during the cycle rst is first raised, before the state register resets.
  assign bus.in_ready  = ~rst & (r_state == IDLE);
  assign sbox_rst      = rst | (r_state == START);
  assign busy          = (r_state != IDLE);
  assign err           = r_err;
  assign bus.out_valid = r_out_valid;
  assign bus.out_s0    = r_out[0];
  assign bus.out_s1    = r_out[1];
  assign bus.out_s2    = r_out[2];
  assign sbox_si_s0    = r_si[0];
  assign sbox_si_s1    = r_si[1];
  assign sbox_si_s2    = r_si[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cap       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < NSHARE; k++) begin
        r_si[k]  <= '0;
        r_out[k] <= '0;
      end
    end else begin
      unique case (r_state)
        // IDLE: accept one nibble, shares go straight onto the S-box inputs
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < NSHARE; k++) r_si[k] <= w_in[k];
            r_state <= START;
          end
        end
        // START: one cycle of sbox_rst restarts the gating controller
        START: begin
          r_cnt   <= '0;
          r_cap   <= 1'b0;
          r_state <= WAIT;
        end
        // WAIT: count until Synch; Synch has priority over the timeout
        WAIT: begin
          if (r_cap) begin
            for (int k = 0; k < NSHARE; k++) r_out[k] <= w_so[k];
            r_out_valid <= 1'b1;
            r_cap       <= 1'b0;
            r_state     <= OUT;
          end else begin
            if (r_cnt < CW'(TIMEOUT)) r_cnt <= r_cnt + CW'(1);
            if (sbox_synch) begin
              r_cap <= 1'b1;
              // Synch before the S-box could have finished is a fault, but
              // the result is still delivered so the consumer never stalls.
              if (r_cnt < CW'(LATENCY - 1)) r_err <= 1'b1;
            end else if (r_cnt >= CW'(TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        // OUT: hold result until the consumer takes it
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
`ifdef SBOX_SEQ_CLEAR_EN
            for (int k = 0; k < NSHARE; k++) r_si[k] <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_share_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sbox_share_sequencer
// Bench for sbox_share_sequencer with a behavioural 3-share Skinny S-box
// model attached. Vectors come from a table; expected results go into a
// scoreboard queue at accept time and are checked at the output handshake.
// ---------------------------------------------------------------------------
module tb_sbox_share_sequencer;

  localparam int NIB = 4;

  logic clk;
  logic rst;
  logic [NIB-1:0] sbox_si_s0, sbox_si_s1, sbox_si_s2;
  logic           sbox_rst;
  logic           sbox_synch;
  logic [NIB-1:0] sbox_so_s0, sbox_so_s1, sbox_so_s2;
  logic           busy;
  logic           err;

  sbox_share_sequencer_if #(.NIB(NIB)) ifc ();

  sbox_share_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc),
    .sbox_si_s0 (sbox_si_s0),
    .sbox_si_s1 (sbox_si_s1),
    .sbox_si_s2 (sbox_si_s2),
    .sbox_rst   (sbox_rst),
    .sbox_synch (sbox_synch),
    .sbox_so_s0 (sbox_so_s0),
    .sbox_so_s1 (sbox_so_s1),
    .sbox_so_s2 (sbox_so_s2),
    .busy       (busy),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- S-box model ----------------
  function automatic logic [3:0] skinny4(input logic [3:0] x);
    case (x)
      4'h0: skinny4 = 4'hC; 4'h1: skinny4 = 4'h6; 4'h2: skinny4 = 4'h9; 4'h3: skinny4 = 4'h0;
      4'h4: skinny4 = 4'h1; 4'h5: skinny4 = 4'hA; 4'h6: skinny4 = 4'h2; 4'h7: skinny4 = 4'hB;
      4'h8: skinny4 = 4'h3; 4'h9: skinny4 = 4'h8; 4'hA: skinny4 = 4'h5; 4'hB: skinny4 = 4'hD;
      4'hC: skinny4 = 4'h4; 4'hD: skinny4 = 4'hE; 4'hE: skinny4 = 4'h7; default: skinny4 = 4'hF;
    endcase
  endfunction

  int       synch_mode = 0;   // 0 normal, 1 never, 2 early
  logic [4:0] mcnt = 5'd31;
  logic [3:0] nm0 = 4'h0, nm1 = 4'h0, lm0 = 4'h0, lm1 = 4'h0;

  always @(posedge clk) begin
    if (sbox_rst) mcnt <= 5'd0;
    else if (mcnt != 5'd31) mcnt <= mcnt + 5'd1;
    if (ifc.in_valid && ifc.in_ready) begin
      lm0 <= nm0;
      lm1 <= nm1;
    end
  end

  assign sbox_synch = (synch_mode == 0) ? (mcnt == 5'd10) :
                      (synch_mode == 2) ? (mcnt == 5'd3)  : 1'b0;
  assign sbox_so_s0 = lm0;
  assign sbox_so_s1 = lm1;
  assign sbox_so_s2 = skinny4(sbox_si_s0 ^ sbox_si_s1 ^ sbox_si_s2) ^ lm0 ^ lm1;

  // ---------------- checking ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [3:0] s0, s1, s2, m0, m1, exp;
    int lat;
    int errx;
    int acc;
  } rec_t;

  rec_t q[$];

  int  stall_left = 0;
  int  acc = 0;
  int  last_hs = 0;
  int  rise_cyc = 0;
  int  hold_err = 0, si_err = 0, busy_err = 0, spurious = 0;
  bit  prev_ov = 1'b0;
  bit  idle_pending = 1'b0;
  logic [3:0] h0, h1, h2;
  logic [3:0] last_s0, last_s1, last_s2;

  // consumer: out_ready low for stall_left cycles once out_valid rises
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (ifc.out_valid && stall_left > 0) begin
        ifc.out_ready = 1'b0;
        stall_left--;
      end else begin
        ifc.out_ready = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (idle_pending) begin
      idle_pending = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", ifc.in_ready, 1);
`ifdef SBOX_SEQ_CLEAR_EN
      chk("si_after_out", {sbox_si_s0, sbox_si_s1, sbox_si_s2}, 0);
`else
      chk("si_after_out", {sbox_si_s0, sbox_si_s1, sbox_si_s2}, {last_s0, last_s1, last_s2});
`endif
    end
    if (q.size() > 0) begin
      if (busy !== 1'b1) busy_err++;
      if ({sbox_si_s0, sbox_si_s1, sbox_si_s2} !== {q[0].s0, q[0].s1, q[0].s2}) si_err++;
    end
    if (ifc.out_valid === 1'b1) begin
      if (!prev_ov) begin
        rise_cyc = cyc;
        h0 = ifc.out_s0; h1 = ifc.out_s1; h2 = ifc.out_s2;
      end else if ({ifc.out_s0, ifc.out_s1, ifc.out_s2} !== {h0, h1, h2}) begin
        hold_err++;
      end
    end
    prev_ov = (ifc.out_valid === 1'b1);
    if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        spurious++;
      end else begin
        rec_t r;
        r = q.pop_front();
        chk("xor", ifc.out_s0 ^ ifc.out_s1 ^ ifc.out_s2, r.exp);
        chk("share0", ifc.out_s0, r.m0);
        chk("share1", ifc.out_s1, r.m1);
        chk("latency", rise_cyc - r.acc, r.lat);
        chk("out_hold", hold_err, 0);
        chk("si_held", si_err, 0);
        chk("busy_op", busy_err, 0);
        chk("err", err, r.errx);
        hold_err = 0; si_err = 0; busy_err = 0;
        last_s0 = r.s0; last_s1 = r.s1; last_s2 = r.s2;
        last_hs = cyc + 1;
        idle_pending = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input logic [3:0] a, b, c, e, input int stall, lat, errx,
                        input bit push, input bit keep);
    bit got;
    rec_t r;
    nm0 = 4'($urandom_range(0, 15));
    nm1 = 4'($urandom_range(0, 15));
    ifc.in_s0 = a; ifc.in_s1 = b; ifc.in_s2 = c;
    ifc.in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) begin
      r.s0 = a; r.s1 = b; r.s2 = c; r.m0 = nm0; r.m1 = nm1; r.exp = e;
      r.lat = lat; r.errx = errx; r.acc = acc;
      q.push_back(r);
      stall_left = stall;
    end
    if (!keep) ifc.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #3;
      if (q.size() == 0 && !idle_pending) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [3:0] s0, s1, s2, exp;
    int stall;
    bit b2b;
  } vec_t;

  vec_t vec[7];

  initial begin
    int k;
    vec[0] = '{4'h5, 4'h3, 4'h6, 4'hC, 0, 1'b0};
    vec[1] = '{4'hA, 4'h2, 4'h9, 4'h6, 5, 1'b0};
    vec[2] = '{4'h1, 4'h4, 4'h7, 4'h9, 0, 1'b1};
    vec[3] = '{4'h6, 4'hC, 4'h9, 4'h0, 0, 1'b0};
    vec[4] = '{4'h0, 4'h0, 4'hF, 4'hF, 2, 1'b0};
    vec[5] = '{4'h3, 4'h3, 4'h8, 4'h3, 0, 1'b0};
    vec[6] = '{4'h1, 4'h2, 4'h6, 4'hA, 1, 1'b0};

    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_s0 = '0; ifc.in_s1 = '0; ifc.in_s2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sbox_rst", sbox_rst, 1);
    chk("rst_in_ready", ifc.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", ifc.in_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", ifc.out_valid, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_sbox_rst", sbox_rst, 0);
    chk("post_rst_si", {sbox_si_s0, sbox_si_s1, sbox_si_s2}, 0);
    chk("post_rst_out_s", {ifc.out_s0, ifc.out_s1, ifc.out_s2}, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vec[i].s0, vec[i].s1, vec[i].s2, vec[i].exp, vec[i].stall, 13, 0, 1'b1, vec[i].b2b);
      if (i > 0 && vec[i-1].b2b) chk("b2b_gap", int'(acc > last_hs), 1);
      if (!vec[i].b2b) wait_done();
    end

    // Synch arriving early: err set, result still delivered
    synch_mode = 2;
    run_op(4'h2, 4'h2, 4'h4, 4'h1, 0, 6, 1, 1'b1, 1'b0);
    wait_done();
    synch_mode = 0;

    // reset in cycle 5 of WAIT discards the operation and clears err
    run_op(4'h7, 4'h0, 4'h0, 4'hB, 0, 13, 0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_sbox_rst", sbox_rst, 1);
    chk("midrst_in_ready", ifc.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", ifc.out_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_in_ready", ifc.in_ready, 1);
    chk("midrst_si", {sbox_si_s0, sbox_si_s1, sbox_si_s2}, 0);
    repeat (20) @(posedge clk);
    #1;
    run_op(vec[0].s0, vec[0].s1, vec[0].s2, vec[0].exp, 0, 13, 0, 1'b1, 1'b0);
    wait_done();

    // Synch never arrives: timeout after 16 WAIT cycles
    synch_mode = 1;
    run_op(4'hE, 4'h1, 4'h1, 4'h7, 0, 13, 0, 1'b0, 1'b0);
    k = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      #1;
      k = j;
      if (err) break;
    end
    chk("timeout_cycles", k, 17);
    @(negedge clk);
    chk("timeout_in_ready", ifc.in_ready, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_out_valid", ifc.out_valid, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("spurious_out", spurious, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
